// File: rtl/cursor_editor.sv
// rtl/cursor_editor.sv - blinking board cursor with cell-write strobes for Game of Life setup
// Optional key auto-repeat is enabled by defining CURSOR_AUTOREPEAT_EN.
module cursor_editor #(
  parameter int ROWS           = 16,
  parameter int COLS           = 16,
  parameter int BLINK_INTERVAL = 250000,
  parameter int WRAP           = 0,
  parameter int REPEAT_DELAY   = 5000000,
  parameter int REPEAT_RATE    = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                KEY,
  input  logic                      SW0,
  input  logic                      start_game,
  output logic [$clog2(ROWS)-1:0]   row_select,
  output logic [$clog2(COLS)-1:0]   col_select,
  output logic                      set_initial,
  output logic                      cell_state,
  output logic [ROWS-1:0][COLS-1:0] GrnPixels
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = (BLINK_INTERVAL > 1) ? $clog2(BLINK_INTERVAL) : 1;

  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_HOME = RW'(ROWS / 2);
  localparam logic [CW-1:0] COL_HOME = CW'(COLS / 2);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_INTERVAL - 1);

  typedef enum logic {EDIT, RUN} state_t;

  state_t          state, state_d;
  logic [3:0]      kq, press;
  logic [RW-1:0]   saved_row, saved_row_d, row_d, row_step;
  logic [CW-1:0]   saved_col, saved_col_d, col_d, col_step;
  logic            strobe_d, cell_d, blink_state, blink_d;
  logic [BW-1:0]   blink_counter, blink_counter_d;
  logic            up, down, left, right, move;

`ifdef CURSOR_AUTOREPEAT_EN
  logic [31:0] rep_cnt;
  logic        rep_armed, rep_fire, held_single;

  // Only one key held steadily in edit mode advances the repeat timer.
  assign held_single = (state == EDIT) && !start_game && (KEY == kq) && $onehot(KEY);
  assign rep_fire    = held_single &&
                       (rep_armed ? (rep_cnt == 32'(REPEAT_RATE - 1))
                                  : (rep_cnt == 32'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (!held_single) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + 32'd1;
    end
  end

  assign press = (KEY & ~kq) | (rep_fire ? KEY : 4'b0000);
`else
  assign press = KEY & ~kq;
`endif

  // Opposite keys pressed together cancel on their axis.
  assign up    = press[2] & ~press[1];
  assign down  = press[1] & ~press[2];
  assign left  = press[0] & ~press[3];
  assign right = press[3] & ~press[0];
  assign move  = up | down | left | right;

  always_comb begin
    row_step = row_select;
    if (up)
      row_step = (row_select == '0) ? ((WRAP != 0) ? ROW_MAX : '0) : row_select - RW'(1);
    else if (down)
      row_step = (row_select == ROW_MAX) ? ((WRAP != 0) ? '0 : ROW_MAX) : row_select + RW'(1);
  end

  always_comb begin
    col_step = col_select;
    if (left)
      col_step = (col_select == '0) ? ((WRAP != 0) ? COL_MAX : '0) : col_select - CW'(1);
    else if (right)
      col_step = (col_select == COL_MAX) ? ((WRAP != 0) ? '0 : COL_MAX) : col_select + CW'(1);
  end

  always_comb begin
    state_d         = state;
    row_d           = row_select;
    col_d           = col_select;
    saved_row_d     = saved_row;
    saved_col_d     = saved_col;
    strobe_d        = 1'b0;
    cell_d          = cell_state;
    blink_d         = blink_state;
    blink_counter_d = blink_counter;
    case (state)
      EDIT: begin
        if (start_game) begin
          state_d         = RUN;
          saved_row_d     = row_select;
          saved_col_d     = col_select;
          blink_d         = 1'b0;
          blink_counter_d = '0;
        end else if (move) begin
          row_d           = row_step;
          col_d           = col_step;
          strobe_d        = 1'b1;
          cell_d          = SW0;
          blink_d         = 1'b1;
          blink_counter_d = '0;
        end else if (blink_counter == BLINK_LAST) begin
          blink_counter_d = '0;
          blink_d         = ~blink_state;
        end else begin
          blink_counter_d = blink_counter + BW'(1);
        end
      end
      RUN: begin
        blink_d         = 1'b0;
        blink_counter_d = '0;
        if (!start_game) begin
          state_d = EDIT;
          row_d   = saved_row;
          col_d   = saved_col;
          blink_d = 1'b1;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= EDIT;
      kq            <= 4'b0000;
      row_select    <= ROW_HOME;
      col_select    <= COL_HOME;
      saved_row     <= ROW_HOME;
      saved_col     <= COL_HOME;
      set_initial   <= 1'b0;
      cell_state    <= 1'b0;
      blink_state   <= 1'b1;
      blink_counter <= '0;
    end else begin
      state         <= state_d;
      kq            <= KEY;
      row_select    <= row_d;
      col_select    <= col_d;
      saved_row     <= saved_row_d;
      saved_col     <= saved_col_d;
      set_initial   <= strobe_d;
      cell_state    <= cell_d;
      blink_state   <= blink_d;
      blink_counter <= blink_counter_d;
    end
  end

  always_comb begin
    GrnPixels = '0;
    if (state == EDIT)
      GrnPixels[row_select][col_select] = blink_state;
  end

endmodule

// File: tb/tb_cursor_editor.sv
// tb/tb_cursor_editor.sv - checks two cursor_editor builds (16x16 saturate, 10x10 wrap) against a model
module tb_cursor_editor;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   KEY = 4'b0000;
  logic         SW0 = 1'b0;
  logic         start_game = 1'b0;

  logic [3:0]        row_a, col_a, row_b, col_b;
  logic              set_a, cell_a, set_b, cell_b;
  logic [15:0][15:0] grn_a;
  logic [9:0][9:0]   grn_b;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  cursor_editor #(.ROWS(16), .COLS(16), .BLINK_INTERVAL(4), .WRAP(0)) dut_a (
    .clk(clk), .reset(reset), .KEY(KEY), .SW0(SW0), .start_game(start_game),
    .row_select(row_a), .col_select(col_a), .set_initial(set_a),
    .cell_state(cell_a), .GrnPixels(grn_a));

  cursor_editor #(.ROWS(10), .COLS(10), .BLINK_INTERVAL(3), .WRAP(1)) dut_b (
    .clk(clk), .reset(reset), .KEY(KEY), .SW0(SW0), .start_game(start_game),
    .row_select(row_b), .col_select(col_b), .set_initial(set_b),
    .cell_state(cell_b), .GrnPixels(grn_b));

  function automatic int dim(int i);  return (i == 0) ? 16 : 10; endfunction
  function automatic int bint(int i); return (i == 0) ? 4 : 3;   endfunction
  function automatic bit wrp(int i);  return i != 0;             endfunction

  // Behavioural model: cursor position as integers, blink from time since last restart.
  int   m_row[2], m_col[2], m_srow[2], m_scol[2], m_age[2];
  bit   m_run[2], m_stb[2], m_cell[2];
  logic [3:0] m_kq;

  function automatic int mv(int v, int n, bit w);
    if (w) return ((v % n) + n) % n;
    if (v < 0) return 0;
    if (v > n - 1) return n - 1;
    return v;
  endfunction

  function automatic logic [255:0] exp_grn(int i);
    logic [255:0] e;
    e = '0;
    if (!m_run[i] && ((m_age[i] / bint(i)) % 2 == 0))
      e[m_row[i] * dim(i) + m_col[i]] = 1'b1;
    return e;
  endfunction

  task automatic model_step(int i, logic [3:0] pr);
    int dr, dc;
    if (!m_run[i]) begin
      if (start_game) begin
        m_run[i] = 1'b1; m_srow[i] = m_row[i]; m_scol[i] = m_col[i]; m_stb[i] = 1'b0;
      end else begin
        dr = int'(pr[1]) - int'(pr[2]);
        dc = int'(pr[3]) - int'(pr[0]);
        if (dr != 0 || dc != 0) begin
          m_row[i] = mv(m_row[i] + dr, dim(i), wrp(i));
          m_col[i] = mv(m_col[i] + dc, dim(i), wrp(i));
          m_stb[i] = 1'b1; m_cell[i] = SW0; m_age[i] = 0;
        end else begin
          m_stb[i] = 1'b0; m_age[i]++;
        end
      end
    end else begin
      m_stb[i] = 1'b0;
      if (!start_game) begin
        m_run[i] = 1'b0; m_row[i] = m_srow[i]; m_col[i] = m_scol[i]; m_age[i] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_row[i] = dim(i) / 2; m_col[i] = dim(i) / 2;
        m_srow[i] = m_row[i]; m_scol[i] = m_col[i];
        m_age[i] = 0; m_run[i] = 1'b0; m_stb[i] = 1'b0; m_cell[i] = 1'b0;
      end
      m_kq = 4'b0000;
    end else begin
      for (int i = 0; i < 2; i++) model_step(i, KEY & ~m_kq);
      m_kq = KEY;
    end
  end

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("row_a", row_a, m_row[0]);   chk("col_a", col_a, m_col[0]);
      chk("set_a", set_a, m_stb[0]);   chk("cell_a", cell_a, m_cell[0]);
      chk("grn_a", grn_a, exp_grn(0));
      chk("row_b", row_b, m_row[1]);   chk("col_b", col_b, m_col[1]);
      chk("set_b", set_b, m_stb[1]);   chk("cell_b", cell_b, m_cell[1]);
      chk("grn_b", grn_b, exp_grn(1));
    end
  end

  task automatic step(logic [3:0] k, logic s, logic g);
    @(negedge clk); #1;
    KEY = k; SW0 = s; start_game = g;
  endtask

  task automatic press(logic [3:0] k, logic s);
    step(k, s, 1'b0);
    step(4'b0000, s, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b0; KEY = 4'b0000; SW0 = 1'b0; start_game = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  int n_stb;

  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;

    // Reset position and visible cursor, then blink off after one half-period.
    @(negedge clk);
    chk("rst_row", row_a, 8); chk("rst_col", col_a, 8);
    chk("rst_set", set_a, 0); chk("rst_pix", grn_a[8][8], 1);
    chk("rst_row_b", row_b, 5);
    repeat (3) @(negedge clk);
    chk("blink_off", grn_a[8][8], 0);

    // Single right press with SW0=1; holding gives nothing more.
    step(4'b1000, 1'b1, 1'b0);
    @(negedge clk);
    chk("p1_col", col_a, 9); chk("p1_set", set_a, 1); chk("p1_cell", cell_a, 1);
    chk("p1_pix", grn_a[8][9], 1);
    repeat (3) @(negedge clk);
    chk("hold_col", col_a, 9); chk("hold_set", set_a, 0);
    step(4'b0000, 1'b0, 1'b0);

    // Saturate at the right edge on A; B wraps 9 -> 0 on its fifth press.
    do_reset();
    n_stb = 0;
    for (int i = 0; i < 9; i++) begin
      step(4'b1000, i[0], 1'b0);
      @(negedge clk);
      if (set_a) n_stb++;
      if (i == 4) chk("wrap_b", col_b, 0);
      step(4'b0000, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("sat_col", col_a, 15); chk("sat_strobes", n_stb, 9);
    for (int i = 0; i < 10; i++) press(4'b0100, 1'b0);
    @(negedge clk);
    chk("sat_row_top", row_a, 0); chk("wrap_row_b", row_b, 5);

    // Cancelling and diagonal presses.
    do_reset();
    step(4'b0110, 1'b1, 1'b0);
    @(negedge clk);
    chk("ud_row", row_a, 8); chk("ud_set", set_a, 0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    @(negedge clk);
    chk("diag_row", row_a, 9); chk("diag_col", col_a, 9); chk("diag_set", set_a, 1);
    step(4'b0000, 1'b0, 1'b0);

    // Move to 3/4, run the game, then return to edit.
    for (int i = 0; i < 6; i++) press(4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) press(4'b0001, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("run_grn", grn_a, 0);
    step(4'b1000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("run_row", row_a, 3); chk("run_col", col_a, 4);
    chk("run_set", set_a, 0); chk("run_grn2", grn_a, 0);
    step(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("back_row", row_a, 3); chk("back_col", col_a, 4); chk("back_pix", grn_a[3][4], 1);
    repeat (10) @(negedge clk);

    // Reset during the strobe cycle.
    step(4'b1000, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_rst_set", set_a, 1);
    #1 reset = 1'b0; KEY = 4'b0000;
    #1 chk("rst_mid_set", set_a, 0); chk("rst_mid_col", col_a, 8); chk("rst_mid_row", row_a, 8);
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_set", set_a, 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
